ps2_move_sequencer: RTL and testbench

//  Turns the PS/2 byte stream (received_data/received_data_en) into single-cycle move/activate

---
 rtl/ps2_move_sequencer_if.sv | 21 ++
 rtl/ps2_move_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ps2_move_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_move_sequencer_if.sv
// Bus between the PS/2 byte receiver and the game-side command consumer.
// master drives scan-code bytes in; slave (the sequencer) drives commands out.
interface ps2_move_sequencer_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       move;
  logic [1:0] dir;
  logic       activate;
  logic [4:0] keys_held;
  logic       seq_error;

  modport master (
    output received_data, received_data_en,
    input  move, dir, activate, keys_held, seq_error
  );

  modport slave (
    input  received_data, received_data_en,
    output move, dir, activate, keys_held, seq_error
  );
endinterface

// File: rtl/ps2_move_sequencer.sv
// PS/2 scan-code decoder that emits rate-limited move pulses, a held dir
// code, activate pulses and a held-key mask. Handles E0/F0 prefixes, the
// E1 Pause sequence, typematic repeat suppression and prefix timeouts.
module ps2_move_sequencer #(
  parameter int          HOLDOFF_CYCLES = 2_500_000,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  ACT_CODE       = 8'h29
) (
  input logic                  clock,
  input logic                  reset,
  ps2_move_sequencer_if.slave  bus
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic          pending_q, pending_d;
  logic [1:0]    pend_dir_q, pend_dir_d;
  logic          move_q, move_d;
  logic [1:0]    dir_q, dir_d;
  logic          activate_q, activate_d;
  logic [4:0]    keys_q, keys_d;
  logic          seq_error_q, seq_error_d;

  // decode-side move request for this cycle
  logic          req;
  logic [1:0]    req_dir;

  wire [7:0] b  = bus.received_data;
  wire       en = bus.received_data_en;

  function automatic logic is_arrow(input logic [7:0] c);
    return (c == 8'h75) || (c == 8'h6B) || (c == 8'h72) || (c == 8'h74);
  endfunction

  // dir code doubles as the keys_held bit index for the arrow
  function automatic logic [1:0] arrow_code(input logic [7:0] c);
    case (c)
      8'h6B:   return 2'd0;
      8'h72:   return 2'd1;
      8'h75:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic is_prefix(input logic [7:0] c);
    return (c == 8'hE0) || (c == 8'hF0) || (c == 8'hE1);
  endfunction

  // byte decode FSM, held-key tracking and prefix timeout
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    keys_d      = keys_q;
    activate_d  = 1'b0;
    seq_error_d = 1'b0;
    req         = 1'b0;
    req_dir     = 2'd0;
    timer_d     = timer_q;

    case (state_q)
      IDLE: if (en) begin
        if (b == 8'hE0)      state_d = EXT;
        else if (b == 8'hF0) state_d = BRK;
        else if (b == 8'hE1) begin
          state_d = DISCARD;
          cnt_d   = 3'd7;
        end else if (b == ACT_CODE && !keys_q[4]) begin
          keys_d[4]  = 1'b1;
          activate_d = 1'b1;
        end
      end
      EXT: if (en) begin
        if (b == 8'hF0) state_d = EXT_BRK;
        else begin
          state_d = IDLE;
          if (is_arrow(b) && !keys_q[arrow_code(b)]) begin
            keys_d[arrow_code(b)] = 1'b1;
            req     = 1'b1;
            req_dir = arrow_code(b);
          end
        end
      end
      BRK: if (en) begin
        state_d = IDLE;
        if (b == ACT_CODE) keys_d[4] = 1'b0;
        if (is_prefix(b))  seq_error_d = 1'b1;
      end
      EXT_BRK: if (en) begin
        state_d = IDLE;
        if (is_arrow(b))  keys_d[arrow_code(b)] = 1'b0;
        if (is_prefix(b)) seq_error_d = 1'b1;
      end
      DISCARD: if (en) begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // timeout only advances on strobe-free cycles, so it never races the decode
    if (state_q == IDLE || en) timer_d = '0;
    else if (timer_q == TO_LAST) begin
      timer_d     = '0;
      state_d     = IDLE;
      seq_error_d = 1'b1;
    end else timer_d = timer_q + TW'(1);
  end

  // move scheduler: holdoff timer with a 1-deep pending slot; drain beats new request
  always_comb begin
    move_d     = 1'b0;
    dir_d      = dir_q;
    pending_d  = pending_q;
    pend_dir_d = pend_dir_q;
    holdoff_d  = (holdoff_q != '0) ? holdoff_q - HW'(1) : '0;

    if (holdoff_q == '0 && pending_q) begin
      move_d    = 1'b1;
      dir_d     = pend_dir_q;
      holdoff_d = HOLD_LOAD;
      pending_d = 1'b0;
      if (req) begin
        pending_d  = 1'b1;
        pend_dir_d = req_dir;
      end
    end else if (req) begin
      if (holdoff_q == '0) begin
        move_d    = 1'b1;
        dir_d     = req_dir;
        holdoff_d = HOLD_LOAD;
      end else begin
        pending_d  = 1'b1;
        pend_dir_d = req_dir;
      end
    end
  end

  // state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      holdoff_q   <= '0;
      pending_q   <= 1'b0;
      pend_dir_q  <= '0;
      move_q      <= 1'b0;
      dir_q       <= '0;
      activate_q  <= 1'b0;
      keys_q      <= '0;
      seq_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      holdoff_q   <= holdoff_d;
      pending_q   <= pending_d;
      pend_dir_q  <= pend_dir_d;
      move_q      <= move_d;
      dir_q       <= dir_d;
      activate_q  <= activate_d;
      keys_q      <= keys_d;
      seq_error_q <= seq_error_d;
    end
  end

  assign bus.move      = move_q;
  assign bus.dir       = dir_q;
  assign bus.activate  = activate_q;
  assign bus.keys_held = keys_q;
  assign bus.seq_error = seq_error_q;

endmodule

// File: tb/tb_ps2_move_sequencer.sv
// Directed bench for ps2_move_sequencer with short holdoff/timeout values.
module tb_ps2_move_sequencer;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  ps2_move_sequencer_if bus ();

  ps2_move_sequencer #(
    .HOLDOFF_CYCLES(8),
    .TIMEOUT_CYCLES(20),
    .ACT_CODE(8'h29)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // caller sits at a negedge; byte is captured by the next posedge and
  // the task returns at the following negedge with the strobe dropped
  task automatic strobe(input logic [7:0] d);
    bus.received_data    = d;
    bus.received_data_en = 1'b1;
    @(negedge clock);
    bus.received_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic count_moves(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clock);
      if (bus.move) c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, c0;
    logic any;
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    reset = 1'b1;
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;
    idle(2);
    chk("rst_move", {7'd0, bus.move}, 8'd0);
    chk("rst_dir", {6'd0, bus.dir}, 8'd0);
    chk("rst_act", {7'd0, bus.activate}, 8'd0);
    chk("rst_keys", {3'd0, bus.keys_held}, 8'd0);
    chk("rst_err", {7'd0, bus.seq_error}, 8'd0);
    reset = 1'b0;
    idle(2);

    // E0,75: UP move one cycle after the final byte
    strobe(8'hE0); strobe(8'h75);
    chk("up_move", {7'd0, bus.move}, 8'd1);
    chk("up_dir", {6'd0, bus.dir}, 8'd2);
    chk("up_keys", {3'd0, bus.keys_held}, 8'h04);
    idle(1);
    chk("up_move_off", {7'd0, bus.move}, 8'd0);
    chk("up_dir_hold", {6'd0, bus.dir}, 8'd2);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
    chk("up_release", {3'd0, bus.keys_held}, 8'h00);
    idle(10);

    // LEFT make, typematic repeat, release
    strobe(8'hE0); strobe(8'h6B);
    chk("left_move", {7'd0, bus.move}, 8'd1);
    chk("left_dir", {6'd0, bus.dir}, 8'd0);
    chk("left_keys", {3'd0, bus.keys_held}, 8'h01);
    strobe(8'hE0); strobe(8'h6B);
    count_moves(12, n);
    chk("left_repeat_moves", 8'(n), 8'd0);
    chk("left_repeat_keys", {3'd0, bus.keys_held}, 8'h01);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h6B);
    chk("left_release", {3'd0, bus.keys_held}, 8'h00);
    idle(10);

    // DOWN then RIGHT inside holdoff: second move lands 8 cycles later
    strobe(8'hE0); strobe(8'h72);
    chk("down_move", {7'd0, bus.move}, 8'd1);
    chk("down_dir", {6'd0, bus.dir}, 8'd1);
    c0 = cyc;
    strobe(8'hE0); strobe(8'h74);
    chk("dr_keys", {3'd0, bus.keys_held}, 8'h0A);
    chk("dr_no_early", {7'd0, bus.move}, 8'd0);
    k = 0;
    while (!bus.move && k < 30) begin
      @(negedge clock);
      k++;
    end
    chk("right_found", {7'd0, bus.move}, 8'd1);
    chk("right_spacing", 8'(cyc - c0), 8'd8);
    chk("right_dir", {6'd0, bus.dir}, 8'd3);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h72);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h74);
    chk("dr_release", {3'd0, bus.keys_held}, 8'h00);
    idle(10);

    // space: activate only, then break clears bit 4
    strobe(8'h29);
    chk("act_pulse", {7'd0, bus.activate}, 8'd1);
    chk("act_no_move", {7'd0, bus.move}, 8'd0);
    chk("act_keys", {3'd0, bus.keys_held}, 8'h10);
    idle(1);
    chk("act_off", {7'd0, bus.activate}, 8'd0);
    strobe(8'hF0); strobe(8'h29);
    chk("act_release", {3'd0, bus.keys_held}, 8'h00);
    chk("act_release_nopulse", {7'd0, bus.activate}, 8'd0);

    // prefix timeout
    strobe(8'hE0);
    k = 0;
    while (!bus.seq_error && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("to_pulse", {7'd0, bus.seq_error}, 8'd1);
    chk("to_latency", 8'(k), 8'd20);
    idle(1);
    chk("to_pulse_off", {7'd0, bus.seq_error}, 8'd0);
    strobe(8'h75);
    count_moves(12, n);
    chk("to_then_75", 8'(n), 8'd0);
    chk("to_keys", {3'd0, bus.keys_held}, 8'h00);

    // Pause sequence is swallowed, FSM returns to IDLE afterwards
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      strobe(pause_seq[i]);
      any = any | bus.move | bus.activate | bus.seq_error;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      any = any | bus.move | bus.activate | bus.seq_error;
    end
    chk("pause_quiet", {7'd0, any}, 8'd0);
    chk("pause_keys", {3'd0, bus.keys_held}, 8'h00);
    strobe(8'h29);
    chk("pause_then_act", {7'd0, bus.activate}, 8'd1);
    strobe(8'hF0); strobe(8'h29);
    idle(10);

    // reset mid E0,F0 sequence with holdoff running and a pending move
    strobe(8'hE0); strobe(8'h74);
    chk("rm_move", {7'd0, bus.move}, 8'd1);
    strobe(8'hE0); strobe(8'h6B);
    strobe(8'hE0); strobe(8'hF0);
    reset = 1'b1;
    #1;
    chk("rm_move_rst", {7'd0, bus.move}, 8'd0);
    chk("rm_dir_rst", {6'd0, bus.dir}, 8'd0);
    chk("rm_keys_rst", {3'd0, bus.keys_held}, 8'h00);
    idle(2);
    reset = 1'b0;
    count_moves(15, n);
    chk("rm_no_drain", 8'(n), 8'd0);
    chk("rm_keys_after", {3'd0, bus.keys_held}, 8'h00);
    strobe(8'h29);
    chk("rm_idle_act", {7'd0, bus.activate}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
